// File: rtl/alu_ctrl_decoder_pkg.sv
// alu_ctrl_decoder_pkg: ALU control codes, ALUOp encodings and the funct decode shared with the EX stage
package alu_ctrl_decoder_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM   = 2'b00,
        ALUOP_BR    = 2'b01,
        ALUOP_ARITH = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_ILL = 4'b1111
    } alu_code_e;

    typedef struct packed {
        alu_code_e code;
        logic      illegal;
    } dec_t;

    // funct7_5 only selects SUB for R-type; I-type ADDI with imm[10]=1 stays ADD
    function automatic dec_t decode(logic [1:0] op, logic [2:0] f3, logic f7_5, logic rtype);
        alu_code_e c;
        c = op == ALUOP_MEM   ? ALU_ADD :
            op == ALUOP_BR    ? ALU_SUB :
            op != ALUOP_ARITH ? ALU_ILL :
            f3 == 3'b000      ? ((rtype && f7_5) ? ALU_SUB : ALU_ADD) :
            f3 == 3'b111      ? ALU_AND :
            f3 == 3'b110      ? ALU_OR :
            f3 == 3'b010      ? ALU_SLT : ALU_ILL;
        return '{code: c, illegal: c == ALU_ILL};
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// alu_ctrl_decoder_if: ID-side decode request and EX-side decoded op handshake
interface alu_ctrl_decoder_if #(parameter int TAG_W = 5, parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             is_rtype;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_control;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        input  in_valid, alu_op, funct3, funct7_5, is_rtype, in_tag, out_ready,
        output in_ready, out_valid, alu_control, out_tag, illegal, illegal_cnt
    );

    modport slave (
        output in_valid, alu_op, funct3, funct7_5, is_rtype, in_tag, out_ready,
        input  in_ready, out_valid, alu_control, out_tag, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_skid.sv
// alu_ctrl_skid: 2-entry valid/ready skid buffer (output reg + skid reg), strictly FIFO
module alu_ctrl_skid #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         ov;
    logic         sv;
    logic [W-1:0] od;
    logic [W-1:0] sd;

    // in_ready is !sv, so a new op is only ever offered when the skid is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov <= 1'b0;
            sv <= 1'b0;
            od <= '0;
            sd <= '0;
        end else if (sv) begin
            if (out_ready) begin
                od <= sd;
                sv <= 1'b0;
            end
        end else if (!ov || out_ready) begin
            ov <= in_valid;
            if (in_valid) od <= in_data;
        end else if (in_valid) begin
            sv <= 1'b1;
            sd <= in_data;
        end
    end

    assign in_ready  = !sv;
    assign out_valid = ov;
    assign out_data  = od;
endmodule

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: registered ID->EX ALU control decode with skid buffer and saturating illegal counter
module alu_ctrl_decoder
    import alu_ctrl_decoder_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    alu_ctrl_decoder_if.master bus
);
    localparam int W = 5 + TAG_W;

    dec_t             dec;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] cnt;

    assign dec = decode(bus.alu_op, bus.funct3, bus.funct7_5, bus.is_rtype);

    alu_ctrl_skid #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({dec, bus.in_tag}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign {bus.alu_control, bus.illegal, bus.out_tag} = out_data;

    // counts accepted inputs, so output backpressure never affects it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (bus.in_valid && bus.in_ready && dec.illegal && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign bus.illegal_cnt = cnt;
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb_alu_ctrl_decoder: directed + random checks of the ALU control decoder against a queue-based model
module tb_alu_ctrl_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] op = '0;
    logic [2:0] f3 = '0;
    logic       f7 = 1'b0;
    logic       rt = 1'b0;
    logic [4:0] tag = '0;

    int         total = 0;
    int         bad = 0;
    logic [9:0] q[$];
    int         cnt = 0;
    int         cnt2 = 0;
    logic       stalled = 1'b0;
    logic [9:0] last = '0;

    alu_ctrl_decoder_if #(.TAG_W(5), .CNT_W(16)) bus ();
    alu_ctrl_decoder_if #(.TAG_W(5), .CNT_W(2))  bus2 ();

    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
    assign bus.alu_op    = op;
    assign bus.funct3    = f3;
    assign bus.funct7_5  = f7;
    assign bus.is_rtype  = rt;
    assign bus.in_tag    = tag;
    assign bus2.in_valid  = in_valid;
    assign bus2.out_ready = out_ready;
    assign bus2.alu_op    = op;
    assign bus2.funct3    = f3;
    assign bus2.funct7_5  = f7;
    assign bus2.is_rtype  = rt;
    assign bus2.in_tag    = tag;

    alu_ctrl_decoder #(.TAG_W(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    alu_ctrl_decoder #(.TAG_W(5), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // reference decode: {code, illegal}
    function automatic logic [4:0] ref_dec(logic [1:0] o, logic [2:0] f, logic s, logic r);
        if (o == 2'b00) return {4'b0010, 1'b0};
        if (o == 2'b01) return {4'b0110, 1'b0};
        if (o == 2'b11) return {4'b1111, 1'b1};
        if (f == 3'b000) return {(r && s) ? 4'b0110 : 4'b0010, 1'b0};
        if (f == 3'b111) return {4'b0000, 1'b0};
        if (f == 3'b110) return {4'b0001, 1'b0};
        if (f == 3'b010) return {4'b0111, 1'b0};
        return {4'b1111, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // called at a negedge with inputs already driven; checks, updates model, advances one cycle
    task automatic cyc();
        logic [9:0] got;
        logic [4:0] d;
        logic       in_x;
        logic       out_x;
        got = {bus.alu_control, bus.illegal, bus.out_tag};
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("payload", 32'(got), 32'(q[0]));
        if (stalled) chk("stall_stable", 32'(got), 32'(last));
        chk("illegal_cnt", 32'(bus.illegal_cnt), cnt);
        chk("illegal_cnt_w2", 32'(bus2.illegal_cnt), cnt2);
        stalled = bus.out_valid && !out_ready;
        last = got;
        in_x = in_valid && q.size() < 2;
        out_x = out_ready && q.size() > 0;
        if (out_x) void'(q.pop_front());
        if (in_x) begin
            d = ref_dec(op, f3, f7, rt);
            q.push_back({d, tag});
            if (d[0]) begin
                if (cnt < 65535) cnt++;
                if (cnt2 < 3) cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [1:0] o, input logic [2:0] f,
                          input logic s, input logic r, input logic [4:0] t);
        in_valid = v;
        op = o;
        f3 = f;
        f7 = s;
        rt = r;
        tag = t;
    endtask

    task automatic directed(input logic [1:0] o, input logic [2:0] f, input logic s, input logic r,
                            input logic [3:0] code, input logic ill);
        out_ready = 1'b1;
        set_in(1'b1, o, f, s, r, 5'd9);
        cyc();
        in_valid = 1'b0;
        chk("dir_code", 32'(bus.alu_control), 32'(code));
        chk("dir_illegal", 32'(bus.illegal), 32'(ill));
        cyc();
    endtask

    initial begin
        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_code", 32'(bus.alu_control), 0);
        chk("rst_tag", 32'(bus.out_tag), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_cnt", 32'(bus.illegal_cnt), 0);

        directed(2'b10, 3'b000, 1'b1, 1'b1, 4'b0110, 1'b0);
        directed(2'b10, 3'b000, 1'b1, 1'b0, 4'b0010, 1'b0);
        directed(2'b10, 3'b111, 1'b0, 1'b1, 4'b0000, 1'b0);
        directed(2'b10, 3'b110, 1'b0, 1'b0, 4'b0001, 1'b0);
        directed(2'b10, 3'b010, 1'b1, 1'b1, 4'b0111, 1'b0);
        directed(2'b10, 3'b001, 1'b0, 1'b1, 4'b1111, 1'b1);
        directed(2'b11, 3'b000, 1'b0, 1'b0, 4'b1111, 1'b1);
        directed(2'b00, 3'b101, 1'b1, 1'b1, 4'b0010, 1'b0);
        directed(2'b01, 3'b011, 1'b0, 1'b0, 4'b0110, 1'b0);

        // full decode sweep, back to back
        out_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            set_in(1'b1, 2'(i >> 5), 3'(i >> 2), i[1], i[0], 5'(i));
            cyc();
        end
        in_valid = 1'b0;
        cyc();

        // streaming tags 0..7
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 5'(i));
            cyc();
            chk("stream_tag", 32'(bus.out_tag), i);
        end
        in_valid = 1'b0;
        cyc();

        // backpressure: tag 1 on output, tag 2 in skid, tag 3 held
        out_ready = 1'b0;
        set_in(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 5'd1);
        cyc();
        set_in(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 5'd2);
        cyc();
        set_in(1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 5'd3);
        chk("bp_ready_low", 32'(bus.in_ready), 0);
        chk("bp_tag_held", 32'(bus.out_tag), 1);
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) cyc();
        in_valid = 1'b0;
        chk("bp_tag3", 32'(bus.out_tag), 3);
        cyc();
        cyc();

        // reset mid-operation with both entries full
        out_ready = 1'b0;
        set_in(1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 5'd20);
        cyc();
        set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 5'd21);
        cyc();
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_cnt", 32'(bus.illegal_cnt), 0);
        q.delete();
        cnt = 0;
        cnt2 = 0;
        stalled = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 32'(bus.in_ready), 1);
        out_ready = 1'b1;
        set_in(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 5'd22);
        cyc();
        in_valid = 1'b0;
        chk("postrst_tag", 32'(bus.out_tag), 22);
        cyc();

        // counter: 5 illegal + 3 legal, then one more illegal
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, i < 5 ? 2'b11 : 2'b00, 3'(i), 1'b0, 1'b0, 5'(i));
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("cnt_five", 32'(bus.illegal_cnt), 5);
        chk("cnt_sat_w2", 32'(bus2.illegal_cnt), 3);
        set_in(1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 5'd30);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("cnt_six", 32'(bus.illegal_cnt), 6);
        chk("cnt_sat_w2_hold", 32'(bus2.illegal_cnt), 3);

        // random traffic; source holds its op while not accepted
        for (int i = 0; i < 10000; i++) begin
            if (!(in_valid && !bus.in_ready))
                set_in(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            out_ready = 1'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
